// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency backing memory among NUM_CH
// requesters; one transaction in flight, with a wait-state timeout and error flag.
module mem_arbiter #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     ch_err,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_addr_valid,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_dout,
  input  logic [DATA_W-1:0]        mem_din,
  input  logic                     mem_din_ready
);

  localparam int unsigned GNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [GNT_W-1:0] grant;
  logic [GNT_W-1:0] last_grant;
  logic [CNT_W-1:0] cnt;
  logic [GNT_W-1:0] pick;
  logic             found;
  logic             timeout_hit;

  // First requesting channel at or after last_grant+1, wrapping around.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      if (!found && ch_valid[GNT_W'((int'(last_grant) + i) % int'(NUM_CH))]) begin
        pick  = GNT_W'((int'(last_grant) + i) % int'(NUM_CH));
        found = 1'b1;
      end
    end
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= '0;
      last_grant     <= GNT_W'(NUM_CH - 1);
      cnt            <= '0;
      mem_addr_valid <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_dout       <= '0;
      ch_done        <= '0;
      ch_err         <= 1'b0;
      ch_rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant          <= pick;
            mem_addr       <= ch_addr[pick*ADDR_W +: ADDR_W];
            mem_dout       <= ch_wdata[pick*DATA_W +: DATA_W];
            mem_we         <= ch_we[pick];
            mem_addr_valid <= 1'b1;
            cnt            <= '0;
            state          <= BUSY;
          end
        end
        BUSY: begin
          // A ready arriving on the last allowed cycle beats the timeout.
          if (mem_din_ready) begin
            ch_rdata <= mem_we ? '0 : mem_din;
            ch_err   <= 1'b0;
          end else if (timeout_hit) begin
            ch_rdata <= '0;
            ch_err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (mem_din_ready || timeout_hit) begin
            mem_addr_valid <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_dout       <= '0;
            ch_done        <= NUM_CH'(1) << grant;
            state          <= DONE;
          end
        end
        DONE: begin
          ch_done    <= '0;
          ch_err     <= 1'b0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory
// requests and completions; monitor processes pop and compare.
module tb_mem_arbiter;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned TO  = 4;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_done;
  logic              ch_err;
  logic [DW-1:0]     ch_rdata;
  logic              mem_addr_valid;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_dout;
  logic [DW-1:0]     mem_din;
  logic              mem_din_ready;

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ch_valid(ch_valid), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_done(ch_done), .ch_err(ch_err), .ch_rdata(ch_rdata),
    .mem_addr_valid(mem_addr_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_din_ready(mem_din_ready)
  );

  typedef struct {
    logic [NCH-1:0] done;
    logic           err;
    logic [DW-1:0]  rdata;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] dout;
    int            len;
  } mreq_t;

  resp_t sb_q[$];
  mreq_t mq[$];

  int            vec = 0;
  int            miscmp = 0;
  int            wait_states = 0;
  logic [DW-1:0] rd_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vec++;
    if (got !== want) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic exp_resp(input logic [NCH-1:0] done, input logic err, input logic [DW-1:0] rdata);
    resp_t r;
    r.done = done; r.err = err; r.rdata = rdata;
    sb_q.push_back(r);
  endtask

  task automatic exp_mem(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] dout, input int len);
    mreq_t m;
    m.addr = addr; m.we = we; m.dout = dout; m.len = len;
    mq.push_back(m);
  endtask

  task automatic set_ch(input int c, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    ch_we[c]            = we;
    ch_addr[c*AW +: AW]  = addr;
    ch_wdata[c*DW +: DW] = wdata;
  endtask

  // Wait for n completions (bounded), then drop all requests in the next cycle.
  task automatic wait_done(input int n, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 200 && seen < n; k++) begin
      @(negedge clk);
      if (ch_done != '0) seen++;
    end
    check({name, "_done_count"}, 64'(seen), 64'(n));
    @(posedge clk);
    #1 ch_valid = '0;
  endtask

  // Completion monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst && ch_done !== '0) begin
        if (sb_q.size() == 0) begin
          vec++; miscmp++;
          $display("FAIL unexpected_done: got %b want none", ch_done);
        end else begin
          r = sb_q.pop_front();
          check("ch_done", 64'(ch_done), 64'(r.done));
          check("ch_err", 64'(ch_err), 64'(r.err));
          check("ch_rdata", ch_rdata, r.rdata);
        end
      end
    end
  end

  // Memory model: answers after wait_states BUSY cycles and checks requests.
  initial begin
    int    busy_cnt;
    bit    have_cur;
    mreq_t cur;
    busy_cnt = 0; have_cur = 0;
    mem_din_ready = 1'b0;
    mem_din = '0;
    forever begin
      @(negedge clk);
      if (mem_addr_valid) begin
        if (busy_cnt == 0) begin
          if (mq.size() == 0) begin
            vec++; miscmp++;
            $display("FAIL unexpected_mem_req: got addr 0x%0h want none", mem_addr);
          end else begin
            cur = mq.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", 64'(mem_we), 64'(cur.we));
          check("mem_dout", mem_dout, cur.dout);
        end
        mem_din_ready = (busy_cnt == wait_states);
        mem_din = rd_data;
        busy_cnt++;
      end else begin
        if (busy_cnt != 0 && have_cur) check("busy_len", 64'(busy_cnt), 64'(cur.len));
        busy_cnt = 0;
        have_cur = 0;
        mem_din_ready = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ch_valid = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    #12;
    check("rst_mem_addr_valid", 64'(mem_addr_valid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_dout", mem_dout, 64'd0);
    check("rst_ch_done", 64'(ch_done), 64'd0);
    check("rst_ch_err", 64'(ch_err), 64'd0);
    check("rst_ch_rdata", ch_rdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single read, zero wait, with explicit latency checks.
    wait_states = 0; rd_data = 64'hDEADBEEF;
    set_ch(0, 1'b0, 64'h40, 64'h0);
    exp_mem(64'h40, 1'b0, 64'h0, 1);
    exp_resp(2'b01, 1'b0, 64'hDEADBEEF);
    ch_valid = 2'b01;
    @(negedge clk);
    check("lat_mem_addr_valid_c1", 64'(mem_addr_valid), 64'd1);
    @(negedge clk);
    check("lat_ch_done_c2", 64'(ch_done), 64'b01);
    check("lat_mem_addr_valid_c2", 64'(mem_addr_valid), 64'd0);
    @(posedge clk);
    #1 ch_valid = '0;
    @(negedge clk);
    check("c3_ch_done", 64'(ch_done), 64'd0);
    check("c3_mem_addr_valid", 64'(mem_addr_valid), 64'd0);
    check("c3_rdata_hold", ch_rdata, 64'hDEADBEEF);

    // Write on ch1 with 3 wait states.
    @(negedge clk);
    wait_states = 3; rd_data = 64'hFFFF;
    set_ch(1, 1'b1, 64'h8, 64'h1234);
    exp_mem(64'h8, 1'b1, 64'h1234, 4);
    exp_resp(2'b10, 1'b0, 64'h0);
    ch_valid = 2'b10;
    wait_done(1, "write");

    // Round-robin fairness: both held for four transactions.
    @(negedge clk);
    wait_states = 0; rd_data = 64'h1111;
    set_ch(0, 1'b0, 64'h100, 64'h0);
    set_ch(1, 1'b0, 64'h200, 64'h0);
    for (int t = 0; t < 2; t++) begin
      exp_mem(64'h100, 1'b0, 64'h0, 1);
      exp_resp(2'b01, 1'b0, 64'h1111);
      exp_mem(64'h200, 1'b0, 64'h0, 1);
      exp_resp(2'b10, 1'b0, 64'h1111);
    end
    ch_valid = 2'b11;
    wait_done(4, "fair");

    // Timeout: memory never responds.
    @(negedge clk);
    wait_states = 1000; rd_data = 64'h5555;
    set_ch(0, 1'b0, 64'h50, 64'h0);
    exp_mem(64'h50, 1'b0, 64'h0, 4);
    exp_resp(2'b01, 1'b1, 64'h0);
    ch_valid = 2'b01;
    wait_done(1, "timeout");
    @(negedge clk);
    check("post_timeout_err", 64'(ch_err), 64'd0);

    // Ready on the final allowed BUSY cycle wins over the timeout.
    wait_states = 3; rd_data = 64'hCAFE;
    set_ch(1, 1'b0, 64'h60, 64'h0);
    exp_mem(64'h60, 1'b0, 64'h0, 4);
    exp_resp(2'b10, 1'b0, 64'hCAFE);
    ch_valid = 2'b10;
    wait_done(1, "coincide");

    // ch0 completes so last_grant=0; then ch1 is granted and reset mid-BUSY.
    @(negedge clk);
    wait_states = 0; rd_data = 64'h7777;
    set_ch(0, 1'b0, 64'h70, 64'h0);
    exp_mem(64'h70, 1'b0, 64'h0, 1);
    exp_resp(2'b01, 1'b0, 64'h7777);
    ch_valid = 2'b01;
    wait_done(1, "pre_reset");
    @(negedge clk);
    wait_states = 1000;
    set_ch(1, 1'b0, 64'h80, 64'h0);
    exp_mem(64'h80, 1'b0, 64'h0, 2);
    ch_valid = 2'b11;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_addr_valid) break;
      end
      check("rst_test_busy_seen", 64'(k < 20), 64'd1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_addr_valid", 64'(mem_addr_valid), 64'd0);
    check("async_rst_ch_done", 64'(ch_done), 64'd0);
    wait_states = 0;
    @(negedge clk);
    rst = 1'b0;
    exp_mem(64'h70, 1'b0, 64'h0, 1);
    exp_resp(2'b01, 1'b0, 64'h7777);
    wait_done(1, "post_reset");

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("mem_drained", 64'(mq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
